// File: rtl/ap_ctx_stack.sv
// ap_ctx_stack: LIFO of accumulator-pointer select values.
// A push saves ap_sel_in. A pop turns the top entry into an AP set code
// (sel+1, where 0 means "hold") and drives it on ap_set_out for one cycle.
// Optional build macro: AP_CTX_STACK_WRAP_EN. When it is defined, a push while
// full overwrites the oldest entry. When it is undefined, that push is dropped.
// ovf is set in both cases.
module ap_ctx_stack #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  logic [2:0]    ap_sel_in,
    output logic [3:0]    ap_set_out,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf
);

    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};

    // Ring storage. It is not reset, because its contents are meaningless while count is 0.
    logic [2:0]    mem [DEPTH];

    logic [PW-1:0] tp_q, tp_d;
    logic [PW:0]   count_q, count_d;
    logic [3:0]    set_q, set_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          we;
    logic [PW-1:0] waddr;
    logic [2:0]    wdata;
    logic          ovf_set;
    logic          unf_set;
    logic          is_full;
    logic          is_empty;
    logic [2:0]    top_val;
    logic [PW-1:0] tp_inc;
    logic [PW-1:0] tp_dec;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);
    assign top_val  = mem[tp_q];
    assign tp_inc   = tp_q + PTR_ONE;
    assign tp_dec   = tp_q - PTR_ONE;

    // Next-state decode for pointer, count, restore code, flags and memory write.
    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        set_d   = 4'd0;
        we      = 1'b0;
        waddr   = tp_inc;
        wdata   = ap_sel_in;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (push && pop) begin
            if (is_empty) begin
                // Pass-through. Nothing is stored.
                set_d = {1'b0, ap_sel_in} + 4'd1;
            end else begin
                // Swap. Restore the top entry and replace it with the current select.
                set_d = {1'b0, top_val} + 4'd1;
                we    = 1'b1;
                waddr = tp_q;
            end
        end else if (push) begin
            if (!is_full) begin
                tp_d    = tp_inc;
                count_d = count_q + CNT_ONE;
                we      = 1'b1;
                waddr   = tp_inc;
            end else begin
                ovf_set = 1'b1;
`ifdef AP_CTX_STACK_WRAP_EN
                // Overwrite the oldest entry. The ring keeps the newest DEPTH contexts.
                tp_d    = tp_inc;
                we      = 1'b1;
                waddr   = tp_inc;
`else
                // Drop the push. Storage, pointer and count are left unchanged.
                we      = 1'b0;
`endif
            end
        end else if (pop) begin
            if (!is_empty) begin
                set_d   = {1'b0, top_val} + 4'd1;
                tp_d    = tp_dec;
                count_d = count_q - CNT_ONE;
            end else begin
                unf_set = 1'b1;
            end
        end

        // Sticky flags. A new error on the same edge as clr_err wins over the clear.
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        unf_d = (unf_q & ~clr_err) | unf_set;
    end

    // State registers, cleared asynchronously by the global active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp_q    <= '0;
            count_q <= '0;
            set_q   <= 4'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            set_q   <= set_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Context storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ap_set_out = set_q;
    assign count      = count_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: tb/tb_ap_ctx_stack.sv
// Directed testbench for ap_ctx_stack. The same bench covers both builds of
// AP_CTX_STACK_WRAP_EN.
module tb_ap_ctx_stack;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [2:0] ap_sel_in;
    logic [3:0] ap_set_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;

    int tests;
    int fails;

    ap_ctx_stack #(.DEPTH(8), .PW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .clr_err    (clr_err),
        .ap_sel_in  (ap_sel_in),
        .ap_set_out (ap_set_out),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of strobes. Inputs are released 1ns after the edge,
    // so outputs are sampled away from the clock.
    task automatic cyc(input logic p, input logic o, input logic c, input logic [2:0] s);
        push = p; pop = o; clr_err = c; ap_sel_in = s;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; ap_sel_in = 3'd0;
        $display("[TB] t=%0t push=%0b pop=%0b clr=%0b sel=%0d -> set=%0d cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 $time, p, o, c, s, ap_set_out, count, full, empty, ovf, unf);
    endtask

    task automatic test_reset;
        // Put the design in a non-trivial state: unf=1, count=3, restore code nonzero.
        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0, 1'b0, 3'd3);
        cyc(1'b1, 1'b0, 1'b0, 3'd4);
        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        tests++;
        if (count !== 4'd3 || ap_set_out !== 4'd5 || unf !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pre_reset_state: cnt=%0d set=%0d unf=%0b, required cnt=3 set=5 unf=1", count, ap_set_out, unf);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (count !== 4'd0 || ap_set_out !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("[TB] FAIL async_reset: cnt=%0d set=%0d ovf=%0b unf=%0b empty=%0b, required 0 0 0 0 1",
                     count, ap_set_out, ovf, unf, empty);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lifo;
        logic [3:0] exp_set [3];
        exp_set[0] = 4'd8; exp_set[1] = 4'd6; exp_set[2] = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0, 1'b0, 3'd5);
        cyc(1'b1, 1'b0, 1'b0, 3'd7);
        tests++;
        if (count !== 4'd3 || ap_set_out !== 4'd0) begin
            fails++;
            $display("[TB] FAIL lifo_fill: cnt=%0d set=%0d, required cnt=3 set=0", count, ap_set_out);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'd0);
            tests++;
            if (ap_set_out !== exp_set[i] || count !== 4'(2 - i)) begin
                fails++;
                $display("[TB] FAIL lifo_pop%0d: set=%0d cnt=%0d, required set=%0d cnt=%0d",
                         i, ap_set_out, count, exp_set[i], 2 - i);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        tests++;
        if (ap_set_out !== 4'd0 || unf !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("[TB] FAIL lifo_idle: set=%0d unf=%0b empty=%0b, required 0 0 1", ap_set_out, unf, empty);
        end
    endtask

    task automatic test_underflow;
        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        tests++;
        if (ap_set_out !== 4'd0 || unf !== 1'b1 || count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL unf_set: set=%0d unf=%0b cnt=%0d, required 0 1 0", ap_set_out, unf, count);
        end
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        tests++;
        if (unf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL unf_clear: unf=%0b, required 0", unf);
        end
        cyc(1'b0, 1'b1, 1'b1, 3'd0);
        tests++;
        if (unf !== 1'b1) begin
            fails++;
            $display("[TB] FAIL unf_set_wins: unf=%0b, required 1", unf);
        end
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        tests++;
        if (unf !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flags_cleared: unf=%0b ovf=%0b, required 0 0", unf, ovf);
        end
    endtask

    task automatic test_swap;
        cyc(1'b1, 1'b0, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd4);
        cyc(1'b1, 1'b1, 1'b0, 3'd1);
        tests++;
        if (ap_set_out !== 4'd5 || count !== 4'd2) begin
            fails++;
            $display("[TB] FAIL swap: set=%0d cnt=%0d, required set=5 cnt=2", ap_set_out, count);
        end
        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        tests++;
        if (ap_set_out !== 4'd2 || count !== 4'd1) begin
            fails++;
            $display("[TB] FAIL swap_pop1: set=%0d cnt=%0d, required set=2 cnt=1", ap_set_out, count);
        end
        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        tests++;
        if (ap_set_out !== 4'd2 || count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL swap_pop2: set=%0d cnt=%0d, required set=2 cnt=0", ap_set_out, count);
        end
    endtask

    task automatic test_passthrough;
        cyc(1'b1, 1'b1, 1'b0, 3'd6);
        tests++;
        if (ap_set_out !== 4'd7 || count !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("[TB] FAIL passthrough: set=%0d cnt=%0d ovf=%0b unf=%0b empty=%0b, required 7 0 0 0 1",
                     ap_set_out, count, ovf, unf, empty);
        end
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        tests++;
        if (ap_set_out !== 4'd0) begin
            fails++;
            $display("[TB] FAIL set_one_cycle: set=%0d, required 0", ap_set_out);
        end
    endtask

    task automatic test_full;
        logic [3:0] exp_set [8];
`ifdef AP_CTX_STACK_WRAP_EN
        exp_set[0] = 4'd4;
        for (int i = 1; i < 8; i++) exp_set[i] = 4'(9 - i);
`else
        for (int i = 0; i < 8; i++) exp_set[i] = 4'(8 - i);
`endif
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 3'(i));
        tests++;
        if (full !== 1'b1 || count !== 4'd8 || ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fill: full=%0b cnt=%0d ovf=%0b, required 1 8 0", full, count, ovf);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd3);
        tests++;
        if (ovf !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_push: ovf=%0b cnt=%0d full=%0b, required 1 8 1", ovf, count, full);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'd0);
            tests++;
            if (ap_set_out !== exp_set[i] || count !== 4'(7 - i)) begin
                fails++;
                $display("[TB] FAIL full_pop%0d: set=%0d cnt=%0d, required set=%0d cnt=%0d",
                         i, ap_set_out, count, exp_set[i], 7 - i);
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        tests++;
        if (ovf !== 1'b0 || empty !== 1'b1 || ap_set_out !== 4'd0) begin
            fails++;
            $display("[TB] FAIL ovf_clear: ovf=%0b empty=%0b set=%0d, required 0 1 0", ovf, empty, ap_set_out);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; ap_sel_in = 3'd0;
        #1;
        tests++;
        if (count !== 4'd0 || ap_set_out !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL initial_reset: cnt=%0d set=%0d empty=%0b full=%0b ovf=%0b unf=%0b, required 0 0 1 0 0 0",
                     count, ap_set_out, empty, full, ovf, unf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_lifo();
        test_underflow();
        test_swap();
        test_passthrough();
        test_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ap_ctx_stack.md
# ap_ctx_stack

Context stack for the accumulator pointer. It captures the current select value (`APSel`) on a push and restores it later on a pop by driving the 4-bit set code that the AP register consumes. The set code is 0 for "no change" and sel+1 otherwise. It sits between the instruction decoder's call/return strobes and the AP register: its input reads APSel, and its output feeds APSet.

## Interface
Parameters:
- `DEPTH`, default 8: number of stored contexts. Must be a power of two, ≥2.
- `PW`, default 3: pointer width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  system clock; every state change happens on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0); this is the global reset, not a clock-derived one.
- `push`  in  1  save `ap_sel_in` on this edge.
- `pop`  in  1  restore the top entry on this edge.
- `clr_err`  in  1  clear the sticky `ovf` and `unf` flags.
- `ap_sel_in`  in  3  current AP select value.
- `ap_set_out`  out  4  set code for the AP register: 0 = hold, 1..8 = select 0..7.
- `count`  out  PW+1  number of valid entries, 0..DEPTH.
- `full`  out  1  high when `count == DEPTH`.
- `empty`  out  1  high when `count == 0`.
- `ovf`  out  1  sticky flag: a push occurred while full.
- `unf`  out  1  sticky flag: a pop occurred while empty.

## Operation
- Storage is a ring of DEPTH entries, 3 bits each, with a top pointer `tp` (PW bits) and `count`.
- `full` and `empty` are combinational from `count`. All other outputs are registered.
- At each edge, `ap_set_out` defaults to 4'd0. It is nonzero for exactly one cycle per successful restore.
- **Push only, not full:** `tp <= tp+1` (mod DEPTH), `mem[tp+1] <= ap_sel_in`, `count <= count+1`.
- **Pop only, not empty:** `ap_set_out <= {1'b0, mem[tp]} + 4'd1`, `tp <= tp-1` (mod DEPTH), `count <= count-1`.
- **Pop only, empty:** `ap_set_out` stays 0, `unf <= 1`, no other state change.
- **Push and pop together, not empty:** swap. `ap_set_out <= mem[tp]+1`, `mem[tp] <= ap_sel_in`; `tp` and `count` are unchanged.
- **Push and pop together, empty:** pass-through. `ap_set_out <= ap_sel_in+1`; nothing is stored and no flag is set.
- **Push only, full:** behaviour is set by the macro (see Configuration). `ovf <= 1` in either build.
- **Sticky flags:** `clr_err` clears `ovf` and `unf`. If a new error occurs on the same edge as `clr_err`, the flag is set; set wins.
- **Arithmetic:** the +1 is done in 4 bits, so 7 maps to 8 and never wraps to 0. Pointer arithmetic wraps modulo DEPTH.
- **Reset (asynchronous, any time, including mid-sequence):** `tp=0`, `count=0`, `ap_set_out=0`, `ovf=0`, `unf=0`. Stack contents are not cleared; they are don't-care while `count` is 0.

## Timing
- **Pop to restore:** a pop sampled at edge N puts the code on `ap_set_out` during cycle N→N+1. The AP register loads it at edge N+1, so APSel shows the restored value after N+1. Latency from pop to new APSel is 2 edges.
- **Push:** samples `ap_sel_in` at the same edge. Callers must not push in the cycle immediately after a pop if they want the restored value, because APSel is not yet updated; the stack does not stall this.
- **Handshake:** none. `push` and `pop` are single-cycle strobes. Back-to-back strobes are legal every cycle.
- `count`, `full` and `empty` reflect the post-edge state in the same cycle that `ap_set_out` is valid.

## Configuration
- **`AP_CTX_STACK_WRAP_EN` defined:** a push while full overwrites the oldest entry. `tp <= tp+1`, `mem[tp+1] <= ap_sel_in`, `count` stays at DEPTH. The newest DEPTH contexts are retained.
- **Not defined:** a push while full is dropped. `mem`, `tp` and `count` are unchanged.
- `ovf` is set on a push while full in both builds.

## Test plan
- **Reset:** hold `rst`=0 mid-cycle with `count`=3. Expect `count`, `ap_set_out`, `ovf` and `unf` at 0 immediately, without a clock, and `empty`=1.
- **LIFO order:** push sel 2, 5, 7, then pop ×3. Expect `ap_set_out` = 8, 6, 3 on consecutive cycles, then 0. `count` goes 3→0, and `unf` stays 0.
- **Underflow and flag clear:** pop when empty. Expect `ap_set_out`=0 and `unf`=1. Pulse `clr_err`, expect `unf`=0. Pulse `clr_err` together with a pop on empty, expect `unf` stays 1.
- **Simultaneous push and pop:**
  - Not empty: with top=4, push+pop with sel 1. Expect `ap_set_out`=5, `count` unchanged, and a following pop gives 2.
  - Empty: push+pop with sel 6. Expect `ap_set_out`=7, `count`=0, and no flags.
- **Full, no macro:** push 0..7 (`full`=1), then push sel 3. Expect `ovf`=1 and `count`=8. Popping ×8 yields 8, 7, …, 1.
- **Full, with `AP_CTX_STACK_WRAP_EN`:** same sequence. Expect `ovf`=1 and `count`=8. Popping ×8 yields 4, 8, 7, 6, 5, 4, 3, 2.
